decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath and immediate width, 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: PC and target width, ADDR_WIDTH <= XLEN.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port instr_i  in  32  instruction word from fetch.
REQ-006 SHALL have port pc_i  in  ADDR_WIDTH  address of instr_i.
REQ-007 SHALL have port instr_valid_i  in  1  fetch offers instr_i/pc_i.
REQ-008 SHALL have port instr_ready_o  out  1  decode accepts this cycle.
REQ-009 SHALL have port out_valid_o  out  1  decoded bundle valid.
REQ-010 SHALL have port out_ready_i  in  1  downstream consumes bundle.
REQ-011 SHALL have ports out_pc_o (ADDR_WIDTH), imm_o (XLEN), opcode_o (7), funct3_o (3), rd_o/rs1_o/rs2_o (5 each), illegal_o (1), pred_taken_o (1), all out, as the registered decoded bundle.
REQ-012 SHALL have port target_addr_o  out  ADDR_WIDTH  redirect address to fetch.
REQ-013 SHALL have port target_valid_o  out  1  redirect request, held until acknowledged.
REQ-014 SHALL have port target_ack_i  in  1  fetch has taken the redirect.

Function
REQ-015 SHALL transfer on instr_valid_i && instr_ready_o; the bundle SHALL appear on out_* the next cycle (latency 1).
REQ-016 SHALL drive instr_ready_o = (!out_valid_o || out_ready_i) in state RUN, and 1 in state REDIRECT.
REQ-017 SHALL hold all out_* stable while out_valid_o && !out_ready_i.
REQ-018 SHALL sustain one instruction per cycle when a transfer and a consume coincide.
REQ-019 SHALL select imm_o by opcode, sign-extended from instr_i[31] to XLEN: I (0010011, 0000011, 1100111), S (0100011), B (1100011, bit0 = 0), U (0110111, 0010111, low 12 bits zero), J (1101111, bit0 = 0).
REQ-020 SHALL zero-extend instr_i[31:20] for opcode 1110011; SHALL drive imm_o = 0 for all other opcodes.
REQ-021 SHALL set illegal_o when instr_i[1:0] != 2'b11 or the opcode is not listed in REQ-019/020 (0110011, 0001111 also legal, imm 0).
REQ-022 SHALL, on accepting JAL, compute target_addr_o = pc_i + imm_J modulo 2^ADDR_WIDTH, assert target_valid_o next cycle, and enter REDIRECT.
REQ-023 SHALL still pass the redirecting instruction downstream as a normal bundle.
REQ-024 SHALL, in REDIRECT, accept and discard every offered instruction (wrong path), including those in the ack cycle; out_valid_o SHALL NOT be set by them.
REQ-025 SHALL return to RUN the cycle after target_valid_o && target_ack_i; target_valid_o SHALL drop in that same next cycle.
REQ-026 SHALL hold target_addr_o stable while target_valid_o is high.
REQ-027 SHALL ignore target_ack_i when target_valid_o is low.

Reset
REQ-028 SHALL, while rst is high, force state RUN and drive out_valid_o = 0, target_valid_o = 0, and all bundle and target registers = 0, asynchronously.
REQ-029 SHALL abandon any pending redirect when rst asserts mid-REDIRECT; no redirect SHALL reappear after release.
REQ-030 SHALL drive instr_ready_o = 0 while rst is high.

Configuration
REQ-031 SHALL, with DECODE_BTFN_EN defined, treat an accepted conditional branch with negative imm_B as taken: redirect per REQ-022 to pc_i + imm_B, pred_taken_o = 1.
REQ-032 SHALL, without DECODE_BTFN_EN, never redirect on branches and tie pred_taken_o to 0.

Verification
REQ-033 SHALL cover: 0xFFF00093 at pc 0x100 -> next cycle out_valid_o = 1, imm_o = all ones, rd_o = 1, rs1_o = 0, illegal_o = 0.
REQ-034 SHALL cover: JAL 0x010000EF at pc 0x200 -> target_valid_o = 1, target_addr_o = 0x210; instr at 0x204 is dropped; ack returns state to RUN.
REQ-035 SHALL cover: out_ready_i = 0 with out_valid_o = 1 -> instr_ready_o = 0 and bundle held; release -> back-to-back transfers with no bubble.
REQ-036 SHALL cover: BEQ 0xFE000CE3 at pc 0x300 -> with DECODE_BTFN_EN, target 0x2F8 and pred_taken_o = 1; without it, no redirect.
REQ-037 SHALL cover: rst pulse during REDIRECT -> target_valid_o and out_valid_o are 0 immediately and stay 0 after release.
REQ-038 SHALL cover: instr_i = 0x00000000 -> illegal_o = 1, imm_o = 0.

Source files
------------

// File: rtl/decode_stage.sv
// Single-issue decode stage: registered decoded bundle with valid/ready handshake and
// JAL redirect (plus backward-taken branch prediction when DECODE_BTFN_EN is defined).
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ADDR_WIDTH-1:0] out_pc_o,
  output logic [XLEN-1:0]       imm_o,
  output logic [6:0]            opcode_o,
  output logic [2:0]            funct3_o,
  output logic [4:0]            rd_o,
  output logic [4:0]            rs1_o,
  output logic [4:0]            rs2_o,
  output logic                  illegal_o,
  output logic                  pred_taken_o,
  output logic [ADDR_WIDTH-1:0] target_addr_o,
  output logic                  target_valid_o,
  input  logic                  target_ack_i
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_REDIRECT = 1'b1} state_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  state_e                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0]       imm_q, imm_d;
  logic [6:0]            opcode_q, opcode_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [4:0]            rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic                  illegal_q, illegal_d;
  logic                  pred_taken_q, pred_taken_d;
  logic [ADDR_WIDTH-1:0] target_addr_q, target_addr_d;
  logic                  target_valid_q, target_valid_d;

  logic [XLEN-1:0]       imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, imm_csr_s, imm_sel_s;
  logic [XLEN-1:0]       redirect_imm_s;
  logic [ADDR_WIDTH-1:0] target_sum_s;
  logic                  legal_s, is_jal_s, br_taken_s, redirect_s, accept_s;

  assign imm_i_s   = XLEN'($signed(instr_i[31:20]));
  assign imm_s_s   = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
  assign imm_b_s   = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
  assign imm_u_s   = XLEN'($signed({instr_i[31:12], 12'b0}));
  assign imm_j_s   = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
  assign imm_csr_s = XLEN'(instr_i[31:20]);

  // Immediate selection and legality by opcode.
  always_comb begin
    imm_sel_s = {XLEN{1'b0}};
    legal_s   = 1'b1;
    case (instr_i[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm_sel_s = imm_i_s;
      OP_STORE:                 imm_sel_s = imm_s_s;
      OP_BRANCH:                imm_sel_s = imm_b_s;
      OP_LUI, OP_AUIPC:         imm_sel_s = imm_u_s;
      OP_JAL:                   imm_sel_s = imm_j_s;
      OP_SYSTEM:                imm_sel_s = imm_csr_s;
      OP_REG, OP_FENCE:         imm_sel_s = {XLEN{1'b0}};
      default:                  legal_s   = 1'b0;
    endcase
  end

  assign is_jal_s = (instr_i[6:0] == OP_JAL);
`ifdef DECODE_BTFN_EN
  assign br_taken_s = (instr_i[6:0] == OP_BRANCH) && imm_b_s[XLEN-1];
`else
  assign br_taken_s = 1'b0;
`endif
  assign redirect_s     = is_jal_s || br_taken_s;
  assign redirect_imm_s = is_jal_s ? imm_j_s : imm_b_s;
  assign target_sum_s   = pc_i + redirect_imm_s[ADDR_WIDTH-1:0];

  // In REDIRECT everything offered is accepted and thrown away as wrong-path.
  assign instr_ready_o = rst ? 1'b0 :
                         (state_q == ST_REDIRECT) ? 1'b1 : (!out_valid_q || out_ready_i);
  assign accept_s = instr_valid_i && instr_ready_o;

  // Next-state for the FSM, the output bundle and the redirect request.
  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    out_pc_d       = out_pc_q;
    imm_d          = imm_q;
    opcode_d       = opcode_q;
    funct3_d       = funct3_q;
    rd_d           = rd_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    illegal_d      = illegal_q;
    pred_taken_d   = pred_taken_q;
    target_addr_d  = target_addr_q;
    target_valid_d = target_valid_q;
    case (state_q)
      ST_RUN: begin
        if (accept_s) begin
          out_valid_d  = 1'b1;
          out_pc_d     = pc_i;
          imm_d        = imm_sel_s;
          opcode_d     = instr_i[6:0];
          funct3_d     = instr_i[14:12];
          rd_d         = instr_i[11:7];
          rs1_d        = instr_i[19:15];
          rs2_d        = instr_i[24:20];
          illegal_d    = !legal_s;
          pred_taken_d = br_taken_s;
          if (redirect_s) begin
            target_valid_d = 1'b1;
            target_addr_d  = target_sum_s;
            state_d        = ST_REDIRECT;
          end else begin
            target_valid_d = 1'b0;
          end
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      ST_REDIRECT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
        if (target_valid_q && target_ack_i) begin
          target_valid_d = 1'b0;
          state_d        = ST_RUN;
        end else begin
          target_valid_d = target_valid_q;
        end
      end
      default: begin
        state_d        = ST_RUN;
        target_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      out_valid_q    <= 1'b0;
      out_pc_q       <= {ADDR_WIDTH{1'b0}};
      imm_q          <= {XLEN{1'b0}};
      opcode_q       <= 7'd0;
      funct3_q       <= 3'd0;
      rd_q           <= 5'd0;
      rs1_q          <= 5'd0;
      rs2_q          <= 5'd0;
      illegal_q      <= 1'b0;
      pred_taken_q   <= 1'b0;
      target_addr_q  <= {ADDR_WIDTH{1'b0}};
      target_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      imm_q          <= imm_d;
      opcode_q       <= opcode_d;
      funct3_q       <= funct3_d;
      rd_q           <= rd_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      illegal_q      <= illegal_d;
      pred_taken_q   <= pred_taken_d;
      target_addr_q  <= target_addr_d;
      target_valid_q <= target_valid_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_pc_o       = out_pc_q;
  assign imm_o          = imm_q;
  assign opcode_o       = opcode_q;
  assign funct3_o       = funct3_q;
  assign rd_o           = rd_q;
  assign rs1_o          = rs1_q;
  assign rs2_o          = rs2_q;
  assign illegal_o      = illegal_q;
  assign pred_taken_o   = pred_taken_q;
  assign target_addr_o  = target_addr_q;
  assign target_valid_o = target_valid_q;

endmodule
